// File: rtl/ula_pkg.sv
// Op codes and FSM encoding for the ULA / MDU, shared with the multicycle control unit.
package ula_pkg;

  localparam logic [4:0] OP_AND   = 5'b0_0000;
  localparam logic [4:0] OP_OR    = 5'b0_0001;
  localparam logic [4:0] OP_ADD   = 5'b0_0010;
  localparam logic [4:0] OP_SLLV  = 5'b0_0011;
  localparam logic [4:0] OP_SRLV  = 5'b0_0100;
  localparam logic [4:0] OP_SRAV  = 5'b0_0101;
  localparam logic [4:0] OP_SUB   = 5'b0_0110;
  localparam logic [4:0] OP_SLT   = 5'b0_0111;
  localparam logic [4:0] OP_SLL   = 5'b0_1001;
  localparam logic [4:0] OP_SRL   = 5'b0_1010;
  localparam logic [4:0] OP_XOR   = 5'b0_1011;
  localparam logic [4:0] OP_NOR   = 5'b0_1100;
  localparam logic [4:0] OP_SRA   = 5'b0_1101;
  localparam logic [4:0] OP_SLTU  = 5'b0_1111;

  localparam logic [4:0] OP_MULT  = 5'b1_0000;
  localparam logic [4:0] OP_MULTU = 5'b1_0001;
  localparam logic [4:0] OP_DIV   = 5'b1_0010;
  localparam logic [4:0] OP_DIVU  = 5'b1_0011;
  localparam logic [4:0] OP_MFHI  = 5'b1_0100;
  localparam logic [4:0] OP_MFLO  = 5'b1_0101;
  localparam logic [4:0] OP_MTHI  = 5'b1_0110;
  localparam logic [4:0] OP_MTLO  = 5'b1_0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // MULT/MULTU/DIV/DIVU: op[1] selects divide, op[0] selects unsigned.
  function automatic logic is_mdu_op(input logic [4:0] op);
    return op[4] && (op[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/ula_mdu_core.sv
// Iterative multiply/divide: WIDTH shift-add or restoring-subtract steps after start, on unsigned magnitudes.
// done is high on the final step; hi_out/lo_out carry the sign-corrected result on that same cycle.
module ula_mdu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] bm_q, bm_d;
  logic             mode_div_q, mode_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0]   a_mag, b_mag, acc_n, mq_n;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod, prod_s;

  always_comb begin
    a_mag   = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag   = (is_signed && b[WIDTH-1]) ? -b : b;
    sum     = {1'b0, acc_q} + {1'b0, bm_q};
    shifted = {acc_q, mq_q[WIDTH-1]};
    diff    = shifted - {1'b0, bm_q};

    // acc < divisor holds between steps, so diff[WIDTH] is the borrow; a zero
    // divisor still leaves the dividend in acc, which is the required remainder.
    if (mode_div_q) begin
      if (!diff[WIDTH]) begin
        acc_n = diff[WIDTH-1:0];
        mq_n  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted[WIDTH-1:0];
        mq_n  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else if (mq_q[0]) begin
      acc_n = sum[WIDTH:1];
      mq_n  = {sum[0], mq_q[WIDTH-1:1]};
    end else begin
      acc_n = {1'b0, acc_q[WIDTH-1:1]};
      mq_n  = {acc_q[0], mq_q[WIDTH-1:1]};
    end

    prod   = {acc_n, mq_n};
    prod_s = neg_lo_q ? -prod : prod;
    if (mode_div_q) begin
      lo_out = dz_q ? {WIDTH{1'b1}} : (neg_lo_q ? -mq_n : mq_n);
      hi_out = neg_hi_q ? -acc_n : acc_n;
    end else begin
      lo_out = prod_s[WIDTH-1:0];
      hi_out = prod_s[2*WIDTH-1:WIDTH];
    end
    done = busy_q && (cnt_q == '0);
    dz   = dz_q;

    busy_d     = busy_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mq_d       = mq_q;
    bm_d       = bm_q;
    mode_div_d = mode_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    if (start) begin
      busy_d     = 1'b1;
      cnt_d      = CNT_W'(WIDTH - 1);
      acc_d      = '0;
      mq_d       = a_mag;
      bm_d       = b_mag;
      mode_div_d = is_div;
      neg_lo_d   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_d   = is_signed && (is_div ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
      dz_d       = is_div && (b == '0);
    end else if (busy_q) begin
      acc_d = acc_n;
      mq_d  = mq_n;
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      bm_q       <= '0;
      mode_div_q <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mq_q       <= mq_d;
      bm_q       <= bm_d;
      mode_div_q <= mode_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
    end
  end

endmodule

// File: rtl/ula_mdu_seq.sv
// ULA with HI/LO and iterative MDU: ALU/HI-LO ops 1 cycle, MDU ops WIDTH cycles; in_ready low while MDU busy, no output backpressure.
// Optional ULA_OVERFLOW_EN adds an overflow output flagging signed ADD/SUB overflow.
module ula_mdu_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ULA_OVERFLOW_EN
  , output logic           overflow
`endif
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d, dz_q, dz_d;
  logic             mdu_div_q, mdu_div_d;

  logic               accept, core_start, core_done, core_dz;
  logic [WIDTH-1:0]   core_hi, core_lo, alu_res, op_res, add_res, sub_res;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign shamt    = in2[SHAMT_W-1:0];
  assign add_res  = in1 + in2;
  assign sub_res  = in1 - in2;

  always_comb begin
    alu_res = '0;
    case (op[3:0])
      OP_AND[3:0]:  alu_res = in1 & in2;
      OP_OR[3:0]:   alu_res = in1 | in2;
      OP_ADD[3:0]:  alu_res = add_res;
      OP_SUB[3:0]:  alu_res = sub_res;
      OP_SLT[3:0]:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_SLTU[3:0]: alu_res = {{(WIDTH-1){1'b0}}, in1 < in2};
      OP_XOR[3:0]:  alu_res = in1 ^ in2;
      OP_NOR[3:0]:  alu_res = ~(in1 | in2);
      OP_SLLV[3:0], OP_SLL[3:0]: alu_res = in1 << shamt;
      OP_SRLV[3:0], OP_SRL[3:0]: alu_res = in1 >> shamt;
      OP_SRAV[3:0], OP_SRA[3:0]: alu_res = WIDTH'($signed(in1) >>> shamt);
      default:      alu_res = '0;
    endcase

    op_res = '0;
    if (!op[4]) op_res = alu_res;
    else begin
      case (op)
        OP_MFHI:          op_res = hi_q;
        OP_MFLO:          op_res = lo_q;
        OP_MTHI, OP_MTLO: op_res = in1;
        default:          op_res = '0;
      endcase
    end
  end

`ifdef ULA_OVERFLOW_EN
  logic overflow_q, overflow_d, add_ovf, sub_ovf;
  assign add_ovf  = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_res[WIDTH-1] != in1[WIDTH-1]);
  assign sub_ovf  = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_res[WIDTH-1] != in1[WIDTH-1]);
  assign overflow = overflow_q;
  always_comb begin
    overflow_d = 1'b0;
    if (accept && (op == OP_ADD)) overflow_d = add_ovf;
    if (accept && (op == OP_SUB)) overflow_d = sub_ovf;
  end
  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    zero_d      = zero_q;
    dz_d        = dz_q;
    mdu_div_d   = mdu_div_q;
    core_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mdu_op(op)) begin
            core_start = 1'b1;
            mdu_div_d  = op[1];
            state_d    = ST_CALC;
          end else begin
            out_valid_d = 1'b1;
            result_d    = op_res;
            zero_d      = (op_res == '0);
            if (op == OP_MTHI) hi_d = in1;
            if (op == OP_MTLO) lo_d = in1;
          end
        end
      end
      ST_CALC: begin
        if (core_done) begin
          hi_d        = core_hi;
          lo_d        = core_lo;
          result_d    = core_lo;
          zero_d      = (core_lo == '0);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
          // div_zero reports the most recent divide; multiplies leave it alone.
          if (mdu_div_q) dz_d = core_dz;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      mdu_div_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      dz_q        <= dz_d;
      mdu_div_q   <= mdu_div_d;
    end
  end

  ula_mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .is_div    (op[1]),
    .is_signed (~op[0]),
    .a         (in1),
    .b         (in2),
    .done      (core_done),
    .hi_out    (core_hi),
    .lo_out    (core_lo),
    .dz        (core_dz)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero_flag = zero_q;
  assign div_zero  = dz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
